// File: rtl/tinytpu_pkg.sv
// Shared defaults, loader state encoding and a counter-width helper for the
// tinytpu host-side loader.
package tinytpu_pkg;

    localparam int D_W_DEF  = 8;
    localparam int N_DEF    = 2;
    localparam int WORD_DEF = N_DEF * N_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT,
        INIT
    } loader_state_t;

    // A counter over a range of one still needs a one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tinytpu_loader_if.sv
// Host word handshake plus the serial lanes toward the tinytpu array.
// The host drives the master side; the loader implements the slave side.
interface tinytpu_loader_if
    import tinytpu_pkg::*;
#(
    parameter int D_W = D_W_DEF
) ();

    logic [D_W-1:0] x_word;
    logic [D_W-1:0] y_word;
    logic           word_valid;
    logic           word_ready;
    logic           data_in_x;
    logic           data_in_y;
    logic           load_en;
    logic           init;
    logic           busy;

    modport master (
        output x_word, y_word, word_valid,
        input  word_ready, data_in_x, data_in_y, load_en, init, busy
    );

    modport slave (
        input  x_word, y_word, word_valid,
        output word_ready, data_in_x, data_in_y, load_en, init, busy
    );

endinterface

// File: rtl/tinytpu_piso.sv
// Parallel-in / serial-out shift register; the serial output is the MSB of
// the register and the contents move toward the MSB on each shift.
module tinytpu_piso #(
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [D_W-1:0] din,
    output logic           msb
);

    logic [D_W-1:0] sr_q;
    logic [D_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[D_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[D_W-1];

endmodule

// File: rtl/tinytpu_loader.sv
// Serialises WORD operand pairs MSB-first onto the tinytpu x/y lanes, with a
// single-entry skid register for back-to-back words, then pulses init.
module tinytpu_loader
    import tinytpu_pkg::*;
#(
    parameter int D_W  = D_W_DEF,
    parameter int WORD = WORD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    tinytpu_loader_if.slave  bus
);

    localparam int BC_W = cnt_width(D_W);
    localparam int WC_W = cnt_width(WORD);
    localparam int AC_W = $clog2(WORD + 1);

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(D_W - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORD - 1);
    localparam logic [AC_W-1:0] ACC_FULL  = AC_W'(WORD);

    loader_state_t   state_q, state_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic [AC_W-1:0] accept_cnt_q, accept_cnt_d;
    logic            hold_full_q, hold_full_d;
    logic [D_W-1:0]  hold_x_q, hold_x_d;
    logic [D_W-1:0]  hold_y_q, hold_y_d;
    logic            load_en_q, load_en_d;
    logic            init_q, init_d;
    logic            busy_q, busy_d;

    logic            word_ready;
    logic            transfer;
    logic            last_bit;
    logic            last_word;
    logic            sr_load;
    logic            sr_shift;
    logic [D_W-1:0]  load_x;
    logic [D_W-1:0]  load_y;

    // Ready only while the frame still has room and the skid slot is free.
    assign word_ready = (state_q != INIT) && !hold_full_q && (accept_cnt_q != ACC_FULL);
    assign transfer   = bus.word_valid && word_ready;
    assign last_bit   = (bit_cnt_q == BIT_LAST);
    assign last_word  = (word_cnt_q == WORD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (last_word) begin
                        state_d = INIT;
                    end else if (!(hold_full_q || transfer)) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (transfer) begin
                    state_d = SHIFT;
                end
            end
            INIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        accept_cnt_d = accept_cnt_q + AC_W'(transfer);
        hold_full_d  = hold_full_q;
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    sr_load    = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    // Reload from the skid slot, or straight from the bus on a same-cycle transfer.
                    if (!last_word && (hold_full_q || transfer)) begin
                        sr_load     = 1'b1;
                        word_cnt_d  = word_cnt_q + WC_W'(1);
                        hold_full_d = 1'b0;
                    end
                end else begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (transfer) begin
                        hold_full_d = 1'b1;
                        hold_x_d    = bus.x_word;
                        hold_y_d    = bus.y_word;
                    end
                end
            end
            WAIT: begin
                if (transfer) begin
                    sr_load    = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = word_cnt_q + WC_W'(1);
                end
            end
            INIT: begin
                accept_cnt_d = '0;
                word_cnt_d   = '0;
            end
            default: begin
                sr_load = 1'b0;
            end
        endcase
        load_en_d = (state_d == SHIFT);
        init_d    = (state_d == INIT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            accept_cnt_q <= '0;
            hold_full_q  <= 1'b0;
            hold_x_q     <= '0;
            hold_y_q     <= '0;
            load_en_q    <= 1'b0;
            init_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            hold_full_q  <= hold_full_d;
            hold_x_q     <= hold_x_d;
            hold_y_q     <= hold_y_d;
            load_en_q    <= load_en_d;
            init_q       <= init_d;
            busy_q       <= busy_d;
        end
    end

    assign load_x = hold_full_q ? hold_x_q : bus.x_word;
    assign load_y = hold_full_q ? hold_y_q : bus.y_word;

    tinytpu_piso #(.D_W(D_W)) u_piso_x (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (load_x),
        .msb   (bus.data_in_x)
    );

    tinytpu_piso #(.D_W(D_W)) u_piso_y (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (load_y),
        .msb   (bus.data_in_y)
    );

    assign bus.word_ready = word_ready;
    assign bus.load_en    = load_en_q;
    assign bus.init       = init_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tinytpu_loader.sv
// Directed bench: a WORD=1 loader for the single-pair case and a default
// WORD=4 loader for back-to-back, overflow, reset, gap and bypass cases.
module tb_tinytpu_loader;

    logic clk;
    logic rst;

    tinytpu_loader_if #(.D_W(8)) a_if ();
    tinytpu_loader_if #(.D_W(8)) b_if ();

    tinytpu_loader #(.D_W(8), .WORD(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    tinytpu_loader #(.D_W(8), .WORD(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int xfer_count = 0;
    int feed_idx   = 0;
    int feed_len   = 0;
    int a_init_cnt = 0;
    int b_init_cnt = 0;

    logic [7:0] fx [0:15];
    logic [7:0] fy [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles with init high, counted at the edge that ends them.
    always @(posedge clk) begin
        if (a_if.init) a_init_cnt <= a_init_cnt + 1;
        if (b_if.init) b_init_cnt <= b_init_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveFeed();
        if (feed_idx < feed_len) begin
            b_if.word_valid = 1'b1;
            b_if.x_word     = fx[feed_idx];
            b_if.y_word     = fy[feed_idx];
        end else begin
            b_if.word_valid = 1'b0;
            b_if.x_word     = 8'h00;
            b_if.y_word     = 8'h00;
        end
    endtask

    // One clock; feeder for the WORD=4 loader advances on each observed transfer.
    task automatic applyStimulus();
        logic xfer;
        xfer = b_if.word_valid && b_if.word_ready;
        @(posedge clk);
        #1;
        if (xfer) begin
            feed_idx++;
            xfer_count++;
        end
        driveFeed();
    endtask

    task automatic checkSerial(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input int hi, input int lo, input bit ready_low);
        for (int i = hi; i >= lo; i--) begin
            checkOutput($sformatf("%s bit%0d load_en", tag, i), b_if.load_en, 1);
            checkOutput($sformatf("%s bit%0d x", tag, i), b_if.data_in_x, x[i]);
            checkOutput($sformatf("%s bit%0d y", tag, i), b_if.data_in_y, y[i]);
            if (ready_low) begin
                checkOutput($sformatf("%s bit%0d ready", tag, i), b_if.word_ready, 0);
            end
            applyStimulus();
        end
    endtask

    initial begin
        logic [7:0] sx;
        logic [7:0] sy;

        fx[0]  = 8'h01; fy[0]  = 8'h10;
        fx[1]  = 8'h02; fy[1]  = 8'h20;
        fx[2]  = 8'h03; fy[2]  = 8'h30;
        fx[3]  = 8'h04; fy[3]  = 8'h40;
        fx[4]  = 8'h81; fy[4]  = 8'h18;
        fx[5]  = 8'hC3; fy[5]  = 8'h3C;
        fx[6]  = 8'h7E; fy[6]  = 8'hE7;
        fx[7]  = 8'h55; fy[7]  = 8'hAA;
        fx[8]  = 8'hA5; fy[8]  = 8'h5A;
        fx[9]  = 8'hFF; fy[9]  = 8'hFF;
        fx[10] = 8'hC5; fy[10] = 8'h5C;
        fx[11] = 8'h96; fy[11] = 8'h69;
        fx[12] = 8'h3A; fy[12] = 8'hA3;
        fx[13] = 8'hE1; fy[13] = 8'h1E;
        fx[14] = 8'h00; fy[14] = 8'h00;
        fx[15] = 8'h00; fy[15] = 8'h00;

        rst             = 1'b1;
        a_if.word_valid = 1'b0;
        a_if.x_word     = 8'h00;
        a_if.y_word     = 8'h00;
        driveFeed();
        applyStimulus();
        applyStimulus();

        // Reset state
        checkOutput("rst a load_en", a_if.load_en, 0);
        checkOutput("rst a init", a_if.init, 0);
        checkOutput("rst a busy", a_if.busy, 0);
        checkOutput("rst a x lane", a_if.data_in_x, 0);
        checkOutput("rst b load_en", b_if.load_en, 0);
        checkOutput("rst b init", b_if.init, 0);
        checkOutput("rst b busy", b_if.busy, 0);
        checkOutput("rst b y lane", b_if.data_in_y, 0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst a ready", a_if.word_ready, 1);
        checkOutput("post-rst b ready", b_if.word_ready, 1);

        // Single pair on the WORD=1 loader
        sx = 8'hA5;
        sy = 8'h3C;
        a_if.word_valid = 1'b1;
        a_if.x_word     = sx;
        a_if.y_word     = sy;
        applyStimulus();
        a_if.word_valid = 1'b0;
        checkOutput("single ready after xfer", a_if.word_ready, 0);
        for (int i = 7; i >= 0; i--) begin
            checkOutput($sformatf("single bit%0d load_en", i), a_if.load_en, 1);
            checkOutput($sformatf("single bit%0d x", i), a_if.data_in_x, sx[i]);
            checkOutput($sformatf("single bit%0d y", i), a_if.data_in_y, sy[i]);
            checkOutput($sformatf("single bit%0d busy", i), a_if.busy, 1);
            applyStimulus();
        end
        checkOutput("single init", a_if.init, 1);
        checkOutput("single init load_en", a_if.load_en, 0);
        checkOutput("single init busy", a_if.busy, 1);
        checkOutput("single init ready", a_if.word_ready, 0);
        applyStimulus();
        checkOutput("single post init", a_if.init, 0);
        checkOutput("single post busy", a_if.busy, 0);
        checkOutput("single post ready", a_if.word_ready, 1);
        checkOutput("single init count", a_init_cnt, 1);

        // Back-to-back frames with ten pairs offered
        feed_len = 10;
        driveFeed();
        applyStimulus();
        checkOutput("b2b xfer count start", xfer_count, 1);
        checkSerial("f1w0", fx[0], fy[0], 7, 0, 1'b0);
        checkSerial("f1w1", fx[1], fy[1], 7, 0, 1'b0);
        checkSerial("f1w2", fx[2], fy[2], 7, 0, 1'b0);
        checkSerial("f1w3", fx[3], fy[3], 7, 0, 1'b1);
        checkOutput("f1 init", b_if.init, 1);
        checkOutput("f1 init load_en", b_if.load_en, 0);
        checkOutput("f1 init ready", b_if.word_ready, 0);
        checkOutput("f1 xfers before init", xfer_count, 4);
        applyStimulus();
        checkOutput("f1 idle init", b_if.init, 0);
        checkOutput("f1 idle load_en", b_if.load_en, 0);
        checkOutput("f1 idle ready", b_if.word_ready, 1);
        checkOutput("f1 idle xfers", xfer_count, 4);
        checkOutput("f1 init count", b_init_cnt, 1);
        applyStimulus();
        checkOutput("f2 fifth xfer", xfer_count, 5);
        checkSerial("f2w0", fx[4], fy[4], 7, 0, 1'b0);
        checkSerial("f2w1", fx[5], fy[5], 7, 0, 1'b0);
        checkSerial("f2w2", fx[6], fy[6], 7, 0, 1'b0);
        checkSerial("f2w3", fx[7], fy[7], 7, 0, 1'b1);
        checkOutput("f2 init", b_if.init, 1);
        checkOutput("f2 xfers before init", xfer_count, 8);
        applyStimulus();
        checkOutput("f2 init count", b_init_cnt, 2);
        applyStimulus();
        checkSerial("f3w0", fx[8], fy[8], 7, 0, 1'b0);
        checkSerial("f3w1", fx[9], fy[9], 7, 5, 1'b0);
        checkOutput("f3 xfers before reset", xfer_count, 10);

        // Asynchronous reset in the middle of a word
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst load_en", b_if.load_en, 0);
        checkOutput("midrst x lane", b_if.data_in_x, 0);
        checkOutput("midrst y lane", b_if.data_in_y, 0);
        checkOutput("midrst init", b_if.init, 0);
        checkOutput("midrst busy", b_if.busy, 0);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("after rst init", b_if.init, 0);
        checkOutput("after rst load_en", b_if.load_en, 0);
        checkOutput("after rst ready", b_if.word_ready, 1);
        checkOutput("after rst init count", b_init_cnt, 2);

        // Gapped feed, then a bypass reload on the last bit
        feed_len = 11;
        driveFeed();
        applyStimulus();
        checkSerial("gapA", fx[10], fy[10], 7, 0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            checkOutput($sformatf("gap%0d load_en", g), b_if.load_en, 0);
            checkOutput($sformatf("gap%0d x hold", g), b_if.data_in_x, fx[10][0]);
            checkOutput($sformatf("gap%0d y hold", g), b_if.data_in_y, fy[10][0]);
            checkOutput($sformatf("gap%0d ready", g), b_if.word_ready, 1);
            checkOutput($sformatf("gap%0d busy", g), b_if.busy, 1);
            applyStimulus();
        end
        feed_len = 12;
        driveFeed();
        applyStimulus();
        checkOutput("gap B xfer", xfer_count, 12);
        checkSerial("gapB", fx[11], fy[11], 7, 1, 1'b0);
        feed_len = 14;
        driveFeed();
        checkOutput("bypass ready", b_if.word_ready, 1);
        checkSerial("gapB", fx[11], fy[11], 0, 0, 1'b0);
        checkOutput("bypass xfer", xfer_count, 13);
        checkSerial("bypC", fx[12], fy[12], 7, 0, 1'b0);
        checkSerial("lastD", fx[13], fy[13], 7, 0, 1'b1);
        checkOutput("f4 init", b_if.init, 1);
        checkOutput("f4 init load_en", b_if.load_en, 0);
        checkOutput("f4 xfers", xfer_count, 14);
        applyStimulus();
        checkOutput("f4 post init", b_if.init, 0);
        checkOutput("f4 post busy", b_if.busy, 0);
        checkOutput("f4 init count", b_init_cnt, 3);
        checkOutput("a init count final", a_init_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
